conv_postproc: RTL and testbench
================================

# conv_postproc

Output post-processing stage directly downstream of the 8-filter 3x3 convolution array. Each cycle it may accept the eight 32-bit signed bias-added accumulators, requantizes each to int8 with a per-layer scale and shift, applies leaky ReLU, and packs the eight bytes into one 64-bit word. Packed words go into a small first-word-fall-through FIFO with a valid/ready output toward the writeback or maxpool stage. The convolution array cannot stall, so a FIFO overflow drops the word and sets a sticky error flag.

## Interface
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- valid_in  in  1  accs valid this cycle; it is the conv array data_valid.
- accs[0:7]  in  32 each  signed accumulators, filter i on index i.
- cfg_scale  in  16  unsigned requant multiplier.
- cfg_shift  in  5  right-shift amount, 0..31.
- cfg_leaky  in  1  leaky ReLU enable; has effect only with the macro defined.
- out_data  out  64  packed int8 results; channel i on bits [8i+7:8i].
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data when it and out_valid are both high.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.

## Operation
- S1 register: when valid_in is high, capture accs, cfg_scale, cfg_shift and cfg_leaky together. Configuration applies per word, so changing it between words is legal.
- S2 multiply, per channel: p = accs[i] * cfg_scale, computed as 32-bit signed times 16-bit unsigned into a 49-bit signed result.
- S3 round and shift: r = (p + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, using an arithmetic shift. This rounds half toward +inf.
- S3 activation: the leaky step (see Configuration) is applied to r, using at least 56-bit intermediates.
- S3 saturate: clamp to [-128, 127], then pack the eight bytes.
- FIFO write occurs on the S3 valid. The FIFO uses circular read and write pointers plus a count, and wraps at FIFO_DEPTH.
- Write while full and out_ready low: the word is dropped, overflow is set to 1, and the count does not change.
- Write while full and a read happens in the same cycle: the write is accepted and the count stays at FIFO_DEPTH.
- Simultaneous read and write at any other count: the count is unchanged.
- A read on an empty FIFO has no effect, because out_valid is low.
- overflow is cleared only by rst.

## Timing
- Reset values: out_data = 0, out_valid = 0, fifo_count = 0, overflow = 0, all pipeline valids = 0. Pointers return to 0.
- Reset asserted mid-operation discards in-flight and buffered words immediately.
- Latency: valid_in in cycle N puts the word in the FIFO at the edge ending cycle N+2. With the FIFO empty, out_valid and out_data appear in cycle N+3.
- Throughput: one word per cycle. Back-to-back valid_in is legal.
- out_data is driven from the FIFO head register (fall-through). It holds stable while out_valid is high and out_ready is low.
- valid_in gaps propagate as bubbles; there is no reordering.

## Configuration
- Macro: CONV_POSTPROC_LEAKY_EN.
- Defined: when cfg_leaky is 1 and r < 0, r is replaced by (r*13) >>> 7, a floor approximation of 0.1x. When cfg_leaky is 0, r passes through unchanged.
- Undefined: no leaky logic is built. cfg_leaky is ignored and r always passes straight to saturation (linear activation).

## Test plan
- Basic: scale=1, shift=0, accs all 100 -> out_data = 0x6464646464646464, out_valid high 3 cycles after valid_in.
- Saturation: scale=1, shift=0, accs[0]=300, accs[1]=-300, others 0 -> bytes 0x7F and 0x80, others 0x00.
- Rounding: scale=3, shift=2, accs[0]=5, accs[1]=-5, accs[2]=6 -> 0x04, 0xFC, 0x05. Expected: 17>>2=4, -13>>>2=-4, 20>>2=5.
- Leaky: scale=1, shift=0, cfg_leaky=1, accs[0]=-100, accs[1]=50 -> with macro 0xF5 (-11) and 0x32; without macro 0x9C and 0x32.
- Backpressure and overflow: FIFO_DEPTH=4, out_ready=0, 6 back-to-back words with distinct values -> fifo_count reaches 4 and overflow=1. Raising out_ready then drains exactly the first 4 words in order.
- Full plus read and reset: FIFO full, out_ready=1 with a concurrent write -> count stays 4 and the new word is retained. Asserting rst mid-stream -> all outputs 0 next cycle, overflow cleared.

Source files
------------

// File: rtl/conv_postproc.sv
// Convolution output post-processing: requantize, activate and saturate eight accumulators to int8,
// then queue the packed word in a fall-through FIFO. Optional leaky ReLU: CONV_POSTPROC_LEAKY_EN.
module conv_postproc #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          valid_in,
    input  logic [31:0]                   accs [0:7],
    input  logic [15:0]                   cfg_scale,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_leaky,
    output logic [63:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    // Stage 1: captured inputs and per-word configuration.
    logic               s1_valid_q;
    logic [31:0]        s1_acc_q [0:7];
    logic [15:0]        s1_scale_q;
    logic [4:0]         s1_shift_q;

    // Stage 2: 49-bit products.
    logic               s2_valid_q;
    logic signed [48:0] s2_prod_q [0:7];
    logic [4:0]         s2_shift_q;
    logic signed [48:0] prod_d [0:7];

    // Stage 3 (combinational into the FIFO write port).
    logic [63:0]        s3_word_d;

    // FIFO state.
    logic [63:0]        mem_q [0:FIFO_DEPTH-1];
    logic [PW-1:0]      wr_ptr_q;
    logic [PW-1:0]      rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic [CW-1:0]      count_d;
    logic               overflow_q;
    logic               fifo_full;
    logic               fifo_rd;
    logic               fifo_wr;

`ifdef CONV_POSTPROC_LEAKY_EN
    logic               s1_leaky_q;
    logic               s2_leaky_q;
`else
    logic               unused_leaky;
    assign unused_leaky = cfg_leaky;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= valid_in;
            s2_valid_q <= s1_valid_q;
        end
    end

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            prod_d[i] = $signed({{17{s1_acc_q[i][31]}}, s1_acc_q[i]}) * $signed({33'd0, s1_scale_q});
        end
    end

    // Datapath registers carry no reset; the stage valids alone qualify them.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            s1_acc_q   <= accs;
            s1_scale_q <= cfg_scale;
            s1_shift_q <= cfg_shift;
`ifdef CONV_POSTPROC_LEAKY_EN
            s1_leaky_q <= cfg_leaky;
`endif
        end
        if (s1_valid_q) begin
            s2_prod_q  <= prod_d;
            s2_shift_q <= s1_shift_q;
`ifdef CONV_POSTPROC_LEAKY_EN
            s2_leaky_q <= s1_leaky_q;
`endif
        end
    end

    // Round half toward +inf, arithmetic shift, optional leaky, clamp to int8.
    always_comb begin
        logic signed [55:0] sum;
        logic signed [55:0] r;
        s3_word_d = '0;
        sum       = '0;
        r         = '0;
        for (int i = 0; i < 8; i++) begin
            sum = {{7{s2_prod_q[i][48]}}, s2_prod_q[i]};
            if (s2_shift_q != 5'd0) begin
                sum = sum + (56'sd1 <<< (s2_shift_q - 5'd1));
            end
            r = sum >>> s2_shift_q;
`ifdef CONV_POSTPROC_LEAKY_EN
            if (s2_leaky_q && r[55]) begin
                r = (r * 56'sd13) >>> 7;
            end
`endif
            if (r > 56'sd127) begin
                s3_word_d[8*i +: 8] = 8'h7f;
            end else if (r < -56'sd128) begin
                s3_word_d[8*i +: 8] = 8'h80;
            end else begin
                s3_word_d[8*i +: 8] = r[7:0];
            end
        end
    end

    // Output handshake: a word transfers on a rising edge where out_valid and out_ready are both
    // high; out_data is held stable while out_valid is high and out_ready is low.
    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign fifo_rd   = out_valid && out_ready;
    assign fifo_wr   = s2_valid_q && (!fifo_full || fifo_rd);

    always_comb begin
        count_d = count_q;
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (fifo_rd) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
            if (s2_valid_q && fifo_full && !fifo_rd) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q] <= s3_word_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : 64'd0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_postproc.sv
// Self-checking bench for conv_postproc: directed test-plan cases, then randomized traffic against
// a queue-based reference model of the requantizer and output FIFO.
module tb_conv_postproc;

    localparam int DEPTH = 4;
`ifdef CONV_POSTPROC_LEAKY_EN
    localparam bit LEAKY_BUILT = 1'b1;
`else
    localparam bit LEAKY_BUILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_in = 1'b0;
    logic [31:0] accs [0:7];
    logic [15:0] cfg_scale = 16'd1;
    logic [4:0]  cfg_shift = 5'd0;
    logic        cfg_leaky = 1'b0;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  fifo_count;
    logic        overflow;

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state: FIFO contents, two-stage latency pipe, sticky overflow.
    logic [63:0] exp_q[$];
    logic        pv_a = 1'b0;
    logic        pv_b = 1'b0;
    logic [63:0] pw_a = '0;
    logic [63:0] pw_b = '0;
    logic        m_ovf = 1'b0;
    logic        m_rd;
    logic        m_full;

    logic [63:0] w6 [0:5];
    logic [63:0] w5;
    logic [63:0] lk_exp;

    conv_postproc #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .accs       (accs),
        .cfg_scale  (cfg_scale),
        .cfg_shift  (cfg_shift),
        .cfg_leaky  (cfg_leaky),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_byte(input logic [31:0] a, input logic [15:0] sc,
                                            input logic [4:0] sh, input logic lk);
        longint v;
        v = longint'($signed(a)) * longint'({48'd0, sc});
        if (sh != 5'd0) v = v + (longint'(1) << (sh - 5'd1));
        v = v >>> sh;
        if ((lk & LEAKY_BUILT) && v < 0) v = (v * 13) >>> 7;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic logic [63:0] ref_word();
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = ref_byte(accs[i], cfg_scale, cfg_shift, cfg_leaky);
        return w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            pv_a  = 1'b0;
            pv_b  = 1'b0;
            m_ovf = 1'b0;
        end else begin
            m_rd   = (exp_q.size() != 0) && out_ready;
            m_full = (exp_q.size() == DEPTH);
            if (m_rd) void'(exp_q.pop_front());
            if (pv_b) begin
                if (!m_full || m_rd) exp_q.push_back(pw_b);
                else m_ovf = 1'b1;
            end
            pv_b = pv_a;
            pw_b = pw_a;
            pv_a = valid_in;
            pw_a = ref_word();
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_model();
        check("m_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        check("m_data", out_data, (exp_q.size() != 0) ? exp_q[0] : 64'd0);
        check("m_count", 64'(fifo_count), 64'(exp_q.size()));
        check("m_ovf", 64'(overflow), 64'(m_ovf));
    endtask

    task tick();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task send();
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task zero_accs();
        for (int i = 0; i < 8; i++) accs[i] = 32'd0;
    endtask

    task rand_word();
        int v;
        for (int i = 0; i < 8; i++) begin
            v = int'($urandom_range(0, 4000)) - 2000;
            accs[i] = ($urandom_range(0, 3) == 0) ? $urandom() : 32'(v);
        end
        cfg_scale = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'($urandom_range(0, 64));
        cfg_shift = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
        cfg_leaky = 1'($urandom_range(0, 1));
    endtask

    initial begin
        zero_accs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", out_data, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();

        // Basic: all 100, latency of three cycles to out_valid.
        for (int i = 0; i < 8; i++) accs[i] = 32'd100;
        send();
        tick();
        check("lat_n2_valid", 64'(out_valid), 64'd0);
        tick();
        check("lat_n3_valid", 64'(out_valid), 64'd1);
        check("basic_data", out_data, 64'h6464646464646464);
        tick();

        // Saturation.
        zero_accs();
        accs[0] = 32'd300;
        accs[1] = 32'hFFFF_FED4;
        send();
        repeat (2) tick();
        check("sat_data", out_data, 64'h0000_0000_0000_807F);
        tick();

        // Rounding.
        zero_accs();
        cfg_scale = 16'd3;
        cfg_shift = 5'd2;
        accs[0] = 32'd5;
        accs[1] = 32'hFFFF_FFFB;
        accs[2] = 32'd6;
        send();
        repeat (2) tick();
        check("round_data", out_data, 64'h0000_0000_0005_FC04);
        tick();

        // Leaky ReLU.
        zero_accs();
        cfg_scale = 16'd1;
        cfg_shift = 5'd0;
        cfg_leaky = 1'b1;
        accs[0] = 32'hFFFF_FF9C;
        accs[1] = 32'd50;
        lk_exp = LEAKY_BUILT ? 64'h0000_0000_0000_32F5 : 64'h0000_0000_0000_329C;
        send();
        cfg_leaky = 1'b0;
        repeat (2) tick();
        check("leaky_data", out_data, lk_exp);
        repeat (2) tick();

        // Backpressure and overflow: six words into a four-entry FIFO.
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < 8; i++) accs[i] = 32'(k * 10 + i + 1);
            w6[k] = ref_word();
            send();
        end
        repeat (3) tick();
        check("ovf_count", 64'(fifo_count), 64'd4);
        check("ovf_flag", 64'(overflow), 64'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data", out_data, w6[k]);
            tick();
        end
        check("drain_empty", 64'(out_valid), 64'd0);

        // Reset clears overflow; then full FIFO with concurrent read and write.
        rst = 1'b1;
        tick();
        check("rst2_ovf", 64'(overflow), 64'd0);
        rst = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) accs[i] = 32'(k * 7 + i + 3);
            w6[k] = ref_word();
            send();
        end
        repeat (2) tick();
        check("full_count", 64'(fifo_count), 64'd4);
        for (int i = 0; i < 8; i++) accs[i] = 32'(-(i + 1) * 9);
        w5 = ref_word();
        send();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("fullrw_count", 64'(fifo_count), 64'd4);
        check("fullrw_ovf", 64'(overflow), 64'd0);
        check("fullrw_head", out_data, w6[1]);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check("fullrw_drain", out_data, w6[k]);
            tick();
        end
        check("fullrw_last", out_data, w5);
        tick();

        // Randomized traffic with a mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                rst = 1'b1;
                valid_in = 1'b0;
                tick();
                check("midrst_data", out_data, 64'd0);
                check("midrst_valid", 64'(out_valid), 64'd0);
                check("midrst_count", 64'(fifo_count), 64'd0);
                check("midrst_ovf", 64'(overflow), 64'd0);
                rst = 1'b0;
            end
            valid_in = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            rand_word();
            tick();
        end
        valid_in = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("final_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
